mul_issue_pipe: RTL and testbench
=================================

Name: mul_issue_pipe

Overview:
- Sequential front/back end for the combinational 64x64 Booth/Wallace core mul_top.
- Accepts RV64M multiply ops from the EXU over a valid/ready handshake and registers the operands.
- Drives mul_top's ai/bi/sign, applies the MULHSU correction, selects the high or low half (or the MULW word), and returns a registered result with backpressure and flush.
- Sits between EXU dispatch and the writeback arbiter.

Parameters:
- TAG_W, 4: width of the opaque tag (ROB/rd id) carried alongside each op.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  op request valid.
- in_ready  output  1  block can accept an op this cycle.
- in_op  input  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 MULW; 101-111 illegal.
- in_src1  input  64  multiplicand a (rs1).
- in_src2  input  64  multiplier b (rs2).
- in_tag  input  TAG_W  tag returned with the result.
- flush  input  1  kill all in-flight ops.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- out_data  output  64  result.
- out_tag  output  TAG_W  tag of the op in out_data.

Behaviour:
- Reset (async, rst=1):
  - All stage valids = 0; out_valid = 0, out_data = 0, out_tag = 0.
  - in_ready = 1 once rst deasserts.
- Stages:
  - S1 holds the operand register: s1_valid, op, a, b, tag.
  - S2 holds the output register: out_valid, out_data, out_tag.
  - mul_top is combinational between S1 and S2.
- Advance rules:
  - s2_adv = s1_valid & (!out_valid | out_ready).
  - in_ready = !s1_valid | s2_adv.
  - Accept = in_valid & in_ready & !flush.
  - Throughput: 1 op/cycle with out_ready held high.
- Latency:
  - Accept at edge N gives out_valid=1 after edge N+1.
  - Result is held stable while out_valid & !out_ready.
- Core drive:
  - ai = a, bi = b.
  - sign = 1 for MUL, MULH, MULW; sign = 0 for MULHU, MULHSU.
- Result select (P = 128-bit core product):
  - MUL: P[63:0].
  - MULH, MULHU: P[127:64].
  - MULHSU: P[127:64] - (a[63] ? b : 0), modulo 2^64.
  - MULW: sign-extend P[31:0] to 64 bits.
  - Illegal op: 0, with out_valid still asserted so the tag retires.
- Flush:
  - On the edge where flush=1, s1_valid and out_valid clear.
  - An op presented the same cycle is not accepted.
  - Flush overrides out_ready and any accept.
  - out_data/out_tag may hold stale values while out_valid=0.
- Simultaneous events:
  - Output drain (out_valid & out_ready) and S1 advance on the same edge: S2 is loaded with the new result, no bubble.
  - Input accept and S1 advance on the same edge: S1 is loaded with the new op.
- Reset mid-operation: all in-flight ops are discarded; no spurious out_valid after release.
- Handshake rule: in_op/src/tag are sampled only on an accept edge.

Optional Feature:
- Macro: MUL_PROD_REG_EN.
- Defined:
  - Adds a middle stage SP that registers the 128-bit P plus op, a[63], b[63:0] and tag between mul_top and the select/correction logic.
  - Latency becomes 2 (accept at N gives out_valid after N+2).
  - Same advance chaining: sp_adv = sp_valid & (!out_valid | out_ready), s1 advances when !sp_valid | sp_adv.
  - Flush clears SP as well.
- Undefined: two-stage pipe as above, latency 1.

Decomposition:
- Shared package mul_pkg holds:
  - The MUL_OP_* 3-bit op encodings (shared with the decoder).
  - XLEN = 64.
  - A function selecting core sign from op.
- Sub-modules:
  - mul_top instantiated as-is.
  - One natural sub-module, mul_result_sel: combinational MULHSU correction plus half/word select, reused by the SP and non-SP builds.

Test Plan:
- MUL a=3, b=5, tag=2, out_ready=1 -> out_valid one cycle after accept (two with MUL_PROD_REG_EN), out_data=15, out_tag=2.
- MULH a=b=0xFFFF_FFFF_FFFF_FFFF -> 0; MULHU same operands -> 0xFFFF_FFFF_FFFF_FFFE.
- MULHSU a=0xFFFF_FFFF_FFFF_FFFF (-1), b=2 -> 0xFFFF_FFFF_FFFF_FFFF; MULW a=0x7FFF_FFFF, b=2 -> 0xFFFF_FFFF_FFFF_FFFE.
- Back-to-back stream of 8 MULs (tags 0..7) with out_ready toggling 1,0,0,1,... -> all 8 results in order, none lost or duplicated, in_ready low only when both stages are full and stalled.
- Flush asserted while S1 and S2 are full and in_valid=1 -> next cycle out_valid=0, in_ready=1; the op presented during flush never appears.
- Assert rst mid-stream with out_valid=1 -> out_valid/out_data/out_tag go 0 immediately (async); after release the first new op returns correct data.

Source files
------------

// File: rtl/mul_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mul_pkg
//  Description : Shared definitions for the RV64M multiply path: operand
//                width, 3-bit op encodings (shared with the decoder) and the
//                core sign-select helper.
//  Revision    : 1.0  initial release
// ============================================================================
package mul_pkg;

    localparam int XLEN = 64;

    localparam logic [2:0] MUL_OP_MUL    = 3'b000;
    localparam logic [2:0] MUL_OP_MULH   = 3'b001;
    localparam logic [2:0] MUL_OP_MULHSU = 3'b010;
    localparam logic [2:0] MUL_OP_MULHU  = 3'b011;
    localparam logic [2:0] MUL_OP_MULW   = 3'b100;

    // Signed core product for MUL/MULH/MULW. MULHSU runs the core unsigned
    // and is corrected afterwards; illegal ops do not care.
    function automatic logic mul_core_sign(input logic [2:0] op);
        return (op == MUL_OP_MUL) || (op == MUL_OP_MULH) || (op == MUL_OP_MULW);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mul_result_sel.sv
`default_nettype none
// ============================================================================
//  Module      : mul_result_sel
//  Description : Combinational result selection for the multiply pipe:
//                low half, high half, MULHSU correction of the unsigned high
//                half, and sign-extended MULW word. Illegal ops return 0.
//  Revision    : 1.0  initial release
// ============================================================================
module mul_result_sel
    import mul_pkg::*;
(
    input  logic [2:0]        i_op,
    input  logic [2*XLEN-1:0] i_prod,
    input  logic              i_a_msb,
    input  logic [XLEN-1:0]   i_b,
    output logic [XLEN-1:0]   o_res
);

    logic [XLEN-1:0] w_hsu_corr;

    // The core runs MULHSU unsigned; a negative rs1 adds 2^64*b too much,
    // so b is subtracted back out of the high half.
    always_comb begin
        w_hsu_corr = i_a_msb ? i_b : '0;
        unique case (i_op)
            MUL_OP_MUL:    o_res = i_prod[XLEN-1:0];
            MUL_OP_MULH:   o_res = i_prod[2*XLEN-1:XLEN];
            MUL_OP_MULHU:  o_res = i_prod[2*XLEN-1:XLEN];
            MUL_OP_MULHSU: o_res = i_prod[2*XLEN-1:XLEN] - w_hsu_corr;
            MUL_OP_MULW:   o_res = {{32{i_prod[31]}}, i_prod[31:0]};
            default:       o_res = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mul_top.sv
`default_nettype none
// ============================================================================
//  Module      : mul_top
//  Description : Combinational 64x64 multiplier core. Produces the full
//                128-bit product, signed x signed when sign=1, otherwise
//                unsigned x unsigned.
//  Revision    : 1.0  initial release
// ============================================================================
module mul_top (
    input  logic [63:0]  ai,
    input  logic [63:0]  bi,
    input  logic         sign,
    output logic [127:0] prod
);

    logic [127:0] w_ext_a;
    logic [127:0] w_ext_b;

    // Extend both operands to 128 bits; the low 128 bits of the product of
    // the extended values is the exact signed or unsigned product.
    always_comb begin
        w_ext_a = {{64{sign & ai[63]}}, ai};
        w_ext_b = {{64{sign & bi[63]}}, bi};
        prod    = w_ext_a * w_ext_b;
    end

endmodule
`default_nettype wire

// File: rtl/mul_issue_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : mul_issue_pipe
//  Description : Pipelined front/back end around the combinational mul_top
//                core. Operand register (S1), optional product register (SP),
//                output register (S2) with valid/ready chaining and flush.
//                Build option: MUL_PROD_REG_EN adds the SP stage (latency 2).
//  Revision    : 1.0  initial release
// ============================================================================
module mul_issue_pipe
    import mul_pkg::*;
#(
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [XLEN-1:0]  in_src1,
    input  logic [XLEN-1:0]  in_src2,
    input  logic [TAG_W-1:0] in_tag,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_data,
    output logic [TAG_W-1:0] out_tag
);

    // S1 operand register
    logic              r_s1_valid;
    logic [2:0]        r_s1_op;
    logic [XLEN-1:0]   r_s1_a;
    logic [XLEN-1:0]   r_s1_b;
    logic [TAG_W-1:0]  r_s1_tag;

    // S2 output register
    logic              r_out_valid;
    logic [XLEN-1:0]   r_out_data;
    logic [TAG_W-1:0]  r_out_tag;

    logic              w_accept;
    logic              w_s1_adv;
    logic              w_out_load;
    logic              w_core_sign;
    logic [2*XLEN-1:0] w_prod;

    // Inputs to the select logic (from S1 + core, or from SP)
    logic [2:0]        w_sel_op;
    logic [2*XLEN-1:0] w_sel_prod;
    logic              w_sel_a_msb;
    logic [XLEN-1:0]   w_sel_b;
    logic [TAG_W-1:0]  w_sel_tag;
    logic [XLEN-1:0]   w_sel_res;

    assign w_core_sign = mul_core_sign(r_s1_op);

    mul_top u_core (
        .ai   (r_s1_a),
        .bi   (r_s1_b),
        .sign (w_core_sign),
        .prod (w_prod)
    );

`ifdef MUL_PROD_REG_EN
    logic              r_sp_valid;
    logic [2:0]        r_sp_op;
    logic [2*XLEN-1:0] r_sp_prod;
    logic              r_sp_a_msb;
    logic [XLEN-1:0]   r_sp_b;
    logic [TAG_W-1:0]  r_sp_tag;
    logic              w_sp_adv;

    assign w_sp_adv   = r_sp_valid & (~r_out_valid | out_ready);
    assign w_s1_adv   = r_s1_valid & (~r_sp_valid | w_sp_adv);
    assign w_out_load = w_sp_adv;

    assign w_sel_op    = r_sp_op;
    assign w_sel_prod  = r_sp_prod;
    assign w_sel_a_msb = r_sp_a_msb;
    assign w_sel_b     = r_sp_b;
    assign w_sel_tag   = r_sp_tag;

    // SP stage: capture the core product when S1 advances, drain into S2
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sp_valid <= 1'b0;
            r_sp_op    <= '0;
            r_sp_prod  <= '0;
            r_sp_a_msb <= 1'b0;
            r_sp_b     <= '0;
            r_sp_tag   <= '0;
        end else if (flush) begin
            r_sp_valid <= 1'b0;
        end else if (w_s1_adv) begin
            r_sp_valid <= 1'b1;
            r_sp_op    <= r_s1_op;
            r_sp_prod  <= w_prod;
            r_sp_a_msb <= r_s1_a[XLEN-1];
            r_sp_b     <= r_s1_b;
            r_sp_tag   <= r_s1_tag;
        end else if (w_sp_adv) begin
            r_sp_valid <= 1'b0;
        end
    end
`else
    assign w_s1_adv   = r_s1_valid & (~r_out_valid | out_ready);
    assign w_out_load = w_s1_adv;

    assign w_sel_op    = r_s1_op;
    assign w_sel_prod  = w_prod;
    assign w_sel_a_msb = r_s1_a[XLEN-1];
    assign w_sel_b     = r_s1_b;
    assign w_sel_tag   = r_s1_tag;
`endif

    mul_result_sel u_sel (
        .i_op    (w_sel_op),
        .i_prod  (w_sel_prod),
        .i_a_msb (w_sel_a_msb),
        .i_b     (w_sel_b),
        .o_res   (w_sel_res)
    );

    assign in_ready = ~r_s1_valid | w_s1_adv;
    assign w_accept = in_valid & in_ready & ~flush;

    // S1: sample operands only on an accept edge; flush kills the held op
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_op    <= '0;
            r_s1_a     <= '0;
            r_s1_b     <= '0;
            r_s1_tag   <= '0;
        end else if (flush) begin
            r_s1_valid <= 1'b0;
        end else if (w_accept) begin
            r_s1_valid <= 1'b1;
            r_s1_op    <= in_op;
            r_s1_a     <= in_src1;
            r_s1_b     <= in_src2;
            r_s1_tag   <= in_tag;
        end else if (w_s1_adv) begin
            r_s1_valid <= 1'b0;
        end
    end

    // S2: load a new result (drain and refill on the same edge), hold on stall
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_tag   <= '0;
        end else if (flush) begin
            r_out_valid <= 1'b0;
        end else if (w_out_load) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_sel_res;
            r_out_tag   <= w_sel_tag;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_tag   = r_out_tag;

endmodule
`default_nettype wire

// File: tb/tb_mul_issue_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mul_issue_pipe
//  Description : Self-checking bench for mul_issue_pipe. Directed and random
//                ops are scored against an arithmetic reference and an
//                in-order queue of expected results.
//                Build option: MUL_PROD_REG_EN (expects latency 2).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mul_issue_pipe;

`ifdef MUL_PROD_REG_EN
    localparam int c_lat = 2;
`else
    localparam int c_lat = 1;
`endif

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_op;
    logic [63:0] in_src1;
    logic [63:0] in_src2;
    logic [3:0]  in_tag;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic [3:0]  out_tag;

    mul_issue_pipe #(.TAG_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_src1   (in_src1),
        .in_src2   (in_src2),
        .in_tag    (in_tag),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_tag   (out_tag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] data;
        logic [3:0]  tag;
        int          acc;
    } ent_t;

    ent_t q[$];
    int   cyc;
    int   n_checks;
    int   n_pass;

    // Reference result straight from the RV64M definitions
    function automatic logic [63:0] ref_res(input logic [2:0] op, input logic [63:0] a,
                                            input logic [63:0] b);
        logic [127:0] sa, sb, ua, ub, pr;
        sa = {{64{a[63]}}, a};
        sb = {{64{b[63]}}, b};
        ua = {64'b0, a};
        ub = {64'b0, b};
        case (op)
            3'd0: begin pr = ua * ub; return pr[63:0]; end
            3'd1: begin pr = sa * sb; return pr[127:64]; end
            3'd2: begin pr = sa * ub; return pr[127:64]; end
            3'd3: begin pr = ua * ub; return pr[127:64]; end
            3'd4: begin pr = ua * ub; return {{32{pr[31]}}, pr[31:0]}; end
            default: return 64'd0;
        endcase
    endfunction

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %h expected %h", name, obs, exp);
    endtask

    // One clock: drive, check in_ready, clock, update model, check outputs
    task automatic step(input logic v, input logic [2:0] op, input logic [63:0] a,
                        input logic [63:0] b, input logic [3:0] tag, input logic rdy,
                        input logic fl, output logic accepted);
        logic exp_ov, exp_ir, pop;
        in_valid  = v;
        in_op     = op;
        in_src1   = a;
        in_src2   = b;
        in_tag    = tag;
        out_ready = rdy;
        flush     = fl;
        #1;
        exp_ov = (q.size() > 0) && (cyc >= q[0].acc + c_lat);
        exp_ir = !((q.size() == c_lat + 1) && !rdy);
        chk("in_ready", {63'b0, in_ready}, {63'b0, exp_ir});
        accepted = v && exp_ir && !fl;
        pop      = exp_ov && rdy && !fl;
        @(posedge clk);
        cyc++;
        if (fl) begin
            q.delete();
        end else begin
            if (pop) void'(q.pop_front());
            if (accepted) q.push_back('{data: ref_res(op, a, b), tag: tag, acc: cyc});
        end
        @(negedge clk);
        exp_ov = (q.size() > 0) && (cyc >= q[0].acc + c_lat);
        chk("out_valid", {63'b0, out_valid}, {63'b0, exp_ov});
        if (exp_ov) begin
            chk("out_data", out_data, q[0].data);
            chk("out_tag", {60'b0, out_tag}, {60'b0, q[0].tag});
        end
    endtask

    task automatic idle(input int n);
        logic acc;
        for (int i = 0; i < n; i++) step(1'b0, 3'd0, 64'd0, 64'd0, 4'd0, 1'b1, 1'b0, acc);
    endtask

    function automatic logic [63:0] rnd_operand();
        case ($urandom_range(0, 5))
            0: return 64'd0;
            1: return 64'd1;
            2: return 64'hFFFF_FFFF_FFFF_FFFF;
            3: return 64'h8000_0000_0000_0000;
            4: return {32'd0, $urandom};
            default: return {$urandom, $urandom};
        endcase
    endfunction

    initial begin
        logic acc;
        int   k;
        int   sent;
        n_checks  = 0;
        n_pass    = 0;
        cyc       = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_op     = 3'd0;
        in_src1   = 64'd0;
        in_src2   = 64'd0;
        in_tag    = 4'd0;
        flush     = 1'b0;
        out_ready = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_out_valid", {63'b0, out_valid}, 64'd0);
        chk("rst_out_data", out_data, 64'd0);
        chk("rst_out_tag", {60'b0, out_tag}, 64'd0);
        rst = 1'b0;

        // Directed single ops, each drained before the next
        step(1'b1, 3'd0, 64'd3, 64'd5, 4'd2, 1'b1, 1'b0, acc);
        idle(3);
        step(1'b1, 3'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 4'd3, 1'b1, 1'b0, acc);
        step(1'b1, 3'd3, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 4'd4, 1'b1, 1'b0, acc);
        step(1'b1, 3'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 4'd5, 1'b1, 1'b0, acc);
        step(1'b1, 3'd4, 64'h7FFF_FFFF, 64'd2, 4'd6, 1'b1, 1'b0, acc);
        step(1'b1, 3'd6, 64'd7, 64'd9, 4'd7, 1'b1, 1'b0, acc);
        idle(4);

        // Back-to-back stream of 8 MULs with out_ready 1,0,0,1,...
        sent = 0;
        k    = 0;
        while (sent < 8 && k < 100) begin
            step(1'b1, 3'd0, 64'(k + 11), 64'd3, 4'(sent),
                 (k % 4 == 0) || (k % 4 == 3), 1'b0, acc);
            if (acc) sent++;
            k++;
        end
        idle(6);

        // Flush with every stage full, stalled, and a new op presented
        k = 0;
        while (q.size() < c_lat + 1 && k < 10) begin
            step(1'b1, 3'd0, 64'(k + 100), 64'd7, 4'(k + 8), 1'b0, 1'b0, acc);
            k++;
        end
        step(1'b1, 3'd0, 64'd55, 64'd55, 4'd15, 1'b1, 1'b1, acc);
        idle(4);

        // Random mix with random backpressure and occasional flush
        for (int i = 0; i < 300; i++) begin
            step($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), rnd_operand(),
                 rnd_operand(), 4'($urandom_range(0, 15)), $urandom_range(0, 2) != 0,
                 $urandom_range(0, 24) == 0, acc);
        end
        idle(4);

        // Asynchronous reset with a stalled result on the output
        step(1'b1, 3'd0, 64'd6, 64'd7, 4'd9, 1'b0, 1'b0, acc);
        step(1'b1, 3'd0, 64'd8, 64'd9, 4'd10, 1'b0, 1'b0, acc);
        step(1'b1, 3'd0, 64'd8, 64'd9, 4'd11, 1'b0, 1'b0, acc);
        #2 rst = 1'b1;
        #1;
        chk("arst_out_valid", {63'b0, out_valid}, 64'd0);
        chk("arst_out_data", out_data, 64'd0);
        chk("arst_out_tag", {60'b0, out_tag}, 64'd0);
        q.delete();
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        idle(3);
        step(1'b1, 3'd0, 64'd12, 64'd12, 4'd1, 1'b1, 1'b0, acc);
        idle(3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
